// File: rtl/cluster_pkg.sv
// Shared widths, word layout and state encoding for the sorted-cluster serializer.
// Header framing constants are consumed only when CLUSTER_SER_HEADER_EN is defined.
package cluster_pkg;

    localparam int MXADRBITS  = 11;
    localparam int MXCNTBITS  = 3;
    localparam int MXCLUSTERS = 8;
    localparam int NCBITS     = $clog2(MXCLUSTERS) + 1;
    localparam int WORDBITS   = MXADRBITS + MXCNTBITS;

    localparam logic [MXADRBITS-1:0] INVALID_ADR = 11'h7FF;

    // Header word: {prefix, frame sequence, cluster count}
    localparam logic [2:0] HDR_PREFIX = 3'b111;
    localparam int         SEQBITS    = WORDBITS - 3 - NCBITS;

    typedef struct packed {
        logic [MXADRBITS-1:0] adr;
        logic [MXCNTBITS-1:0] cnt;
    } cluster_t;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

endpackage

// File: rtl/cluster_serializer_if.sv
// Valid/ready word stream from the serializer toward the link formatter.
// tx_sof exists only when CLUSTER_SER_HEADER_EN is defined.
interface cluster_serializer_if;
    import cluster_pkg::*;

    logic [WORDBITS-1:0] tx_data;
    logic                tx_valid;
    logic                tx_ready;
    logic                tx_last;
`ifdef CLUSTER_SER_HEADER_EN
    logic                tx_sof;
`endif

    modport master (
        input  tx_ready,
        output tx_data, tx_valid, tx_last
`ifdef CLUSTER_SER_HEADER_EN
        , tx_sof
`endif
    );

    modport slave (
        output tx_ready,
        input  tx_data, tx_valid, tx_last
`ifdef CLUSTER_SER_HEADER_EN
        , tx_sof
`endif
    );

endinterface

// File: rtl/cluster_prefix_count.sv
// Counts the valid clusters of a sorted frame: index of the first empty slot,
// or MXCLUSTERS when every slot holds a real address.
module cluster_prefix_count
    import cluster_pkg::*;
(
    input  logic [MXCLUSTERS*MXADRBITS-1:0] adr_i,
    output logic [NCBITS-1:0]               nclusters_o
);

    // Scanning from the top lets the lowest empty slot win.
    always_comb begin
        nclusters_o = NCBITS'(MXCLUSTERS);
        for (int i = MXCLUSTERS - 1; i >= 0; i--) begin
            if (adr_i[i*MXADRBITS +: MXADRBITS] == INVALID_ADR) begin
                nclusters_o = NCBITS'(i);
            end
        end
    end

endmodule

// File: rtl/cluster_serializer.sv
// Serializes one sorted cluster frame into a last-delimited valid/ready word stream.
// Optional CLUSTER_SER_HEADER_EN prepends a {prefix, seq, nclusters} header word per frame.
module cluster_serializer
    import cluster_pkg::*;
(
    input  logic                            clock4x,
    input  logic                            reset,
    input  logic                            load,
    input  logic [MXCLUSTERS*MXADRBITS-1:0] adr_in,
    input  logic [MXCLUSTERS*MXCNTBITS-1:0] cnt_in,
    output logic                            load_ready,
    output logic [NCBITS-1:0]               nclusters,
    output logic [7:0]                      overflow_cnt,
    cluster_serializer_if.master            tx
);

    logic [0:0]                 state_q, state_d;
    logic [NCBITS-1:0]          idx_q, idx_d;
    logic [NCBITS-1:0]          ncl_q, ncl_in;
    logic [7:0]                 ovf_q;
    cluster_t [MXCLUSTERS-1:0]  slot_q, load_slot;

    logic                       accept, drop, beat;
    logic [WORDBITS-1:0]        out_data;
    logic                       out_valid, out_last;

`ifdef CLUSTER_SER_HEADER_EN
    logic                       hdr_q, hdr_d;
    logic [SEQBITS-1:0]         seq_q;
    logic                       out_sof;
`endif

    cluster_prefix_count u_prefix_count (
        .adr_i       (adr_in),
        .nclusters_o (ncl_in)
    );

    assign load_ready = (state_q == ST_IDLE);
    assign accept     = load & load_ready;
    assign drop       = load & ~load_ready;
    assign beat       = out_valid & tx.tx_ready;

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        load_slot = '0;
        for (int i = 0; i < MXCLUSTERS; i++) begin
            load_slot[i].adr = adr_in[i*MXADRBITS +: MXADRBITS];
            load_slot[i].cnt = cnt_in[i*MXCNTBITS +: MXCNTBITS];
        end
    end

    // An empty frame still emits one invalid word so each load yields one delimited frame.
    always_comb begin
        out_valid = (state_q == ST_SEND);
        out_data  = '0;
        out_last  = 1'b0;
        if (out_valid) begin
            if (ncl_q == '0) begin
                out_data = {INVALID_ADR, {MXCNTBITS{1'b0}}};
                out_last = 1'b1;
            end else begin
                out_data = slot_q[idx_q[NCBITS-2:0]];
                out_last = (idx_q == ncl_q - 1'b1);
            end
        end
`ifdef CLUSTER_SER_HEADER_EN
        out_sof = 1'b0;
        if (out_valid && hdr_q) begin
            out_data = {HDR_PREFIX, seq_q, ncl_q};
            out_last = 1'b0;
            out_sof  = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
`ifdef CLUSTER_SER_HEADER_EN
        hdr_d   = hdr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    state_d = ST_SEND;
                    idx_d   = '0;
`ifdef CLUSTER_SER_HEADER_EN
                    hdr_d   = 1'b1;
`endif
                end
            end
            default: begin
                if (beat) begin
`ifdef CLUSTER_SER_HEADER_EN
                    if (hdr_q) hdr_d = 1'b0;
                    else
`endif
                    if (out_last) state_d = ST_IDLE;
                    else          idx_d   = idx_q + 1'b1;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock4x) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            ncl_q   <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (accept) ncl_q <= ncl_in;
            if (drop && ovf_q != 8'hFF) ovf_q <= ovf_q + 8'd1;
        end
    end

    // NOTE: the slot store has no reset; it is only read after a load has rewritten it.
    always_ff @(posedge clock4x) begin
        if (accept) slot_q <= load_slot;
    end

`ifdef CLUSTER_SER_HEADER_EN
    // Counting header acceptances matches counting accepted loads: every load sends one header.
    always_ff @(posedge clock4x) begin
        if (reset) begin
            hdr_q <= 1'b0;
            seq_q <= '0;
        end else begin
            hdr_q <= hdr_d;
            if (beat && hdr_q) seq_q <= seq_q + 1'b1;
        end
    end
    assign tx.tx_sof = out_sof;
`endif

    assign tx.tx_data    = out_data;
    assign tx.tx_valid   = out_valid;
    assign tx.tx_last    = out_last;
    assign nclusters     = ncl_q;
    assign overflow_cnt  = ovf_q;

endmodule

// File: tb/tb_cluster_serializer.sv
// Randomized scoreboard bench for cluster_serializer; expected frames are built from
// the frame rules when a load is issued and popped by an independent output monitor.
`timescale 1ns/1ps
module tb_cluster_serializer;
    import cluster_pkg::*;

    typedef struct {
        logic [WORDBITS-1:0] data;
        logic                last;
        logic                sof;
    } exp_t;

    logic                            clock4x = 1'b0;
    logic                            reset   = 1'b1;
    logic                            load    = 1'b0;
    logic [MXCLUSTERS*MXADRBITS-1:0] adr_in  = '0;
    logic [MXCLUSTERS*MXCNTBITS-1:0] cnt_in  = '0;
    logic                            load_ready;
    logic [NCBITS-1:0]               nclusters;
    logic [7:0]                      overflow_cnt;

    cluster_serializer_if tx_if ();

    cluster_serializer dut (
        .clock4x      (clock4x),
        .reset        (reset),
        .load         (load),
        .adr_in       (adr_in),
        .cnt_in       (cnt_in),
        .load_ready   (load_ready),
        .nclusters    (nclusters),
        .overflow_cnt (overflow_cnt),
        .tx           (tx_if)
    );

    always #5 clock4x = ~clock4x;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   model_ovf = 0;
    int   model_ncl = 0;
    int   model_seq = 0;
    logic expect_valid = 1'b0;
    logic prev_rst = 1'b0;

    logic [MXCLUSTERS*MXADRBITS-1:0] fa;
    logic [MXCLUSTERS*MXCNTBITS-1:0] fc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: frame ends at the first empty slot; an empty frame is one invalid word.
    task automatic push_frame(input logic [MXCLUSTERS*MXADRBITS-1:0] a,
                              input logic [MXCLUSTERS*MXCNTBITS-1:0] c);
        int   n;
        exp_t e;
        n = MXCLUSTERS;
        for (int i = 0; i < MXCLUSTERS; i++) begin
            if (a[i*MXADRBITS +: MXADRBITS] == 11'h7FF) begin
                n = i;
                break;
            end
        end
        model_ncl = n;
`ifdef CLUSTER_SER_HEADER_EN
        e.data = {3'b111, 7'(model_seq), 4'(n)};
        e.last = 1'b0;
        e.sof  = 1'b1;
        exp_q.push_back(e);
        model_seq = (model_seq + 1) % 128;
`endif
        if (n == 0) begin
            e.data = {11'h7FF, 3'b000};
            e.last = 1'b1;
            e.sof  = 1'b0;
            exp_q.push_back(e);
        end else begin
            for (int k = 0; k < n; k++) begin
                e.data = {a[k*MXADRBITS +: MXADRBITS], c[k*MXCNTBITS +: MXCNTBITS]};
                e.last = (k == n - 1);
                e.sof  = 1'b0;
                exp_q.push_back(e);
            end
        end
    endtask

    // One clock cycle: check post-edge state against the model, then drive this cycle.
    task automatic step(input logic ld, input logic [MXCLUSTERS*MXADRBITS-1:0] a,
                        input logic [MXCLUSTERS*MXCNTBITS-1:0] c,
                        input logic rdy, input logic rst);
        @(posedge clock4x);
        #1;
        check("load_ready", load_ready, exp_q.size() == 0);
        check("overflow_cnt", overflow_cnt, model_ovf);
        check("nclusters", nclusters, model_ncl);
        if (expect_valid) begin
            check("first beat tx_valid", tx_if.tx_valid, 1'b1);
            if (exp_q.size() != 0) check("first beat tx_data", tx_if.tx_data, exp_q[0].data);
        end
        if (prev_rst) begin
            check("reset tx_valid", tx_if.tx_valid, 1'b0);
            check("reset tx_last", tx_if.tx_last, 1'b0);
            check("reset tx_data", tx_if.tx_data, '0);
        end
        expect_valid = 1'b0;
        prev_rst     = rst;
        reset        = rst;
        load         = ld;
        adr_in       = a;
        cnt_in       = c;
        tx_if.tx_ready = rdy;
        if (rst) begin
            exp_q.delete();
            model_ovf = 0;
            model_ncl = 0;
            model_seq = 0;
        end else if (ld) begin
            if (exp_q.size() == 0) begin
                push_frame(a, c);
                expect_valid = 1'b1;
            end else if (model_ovf < 255) begin
                model_ovf++;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
        check("drain timeout words left", exp_q.size(), 0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic make_ramp();
        for (int i = 0; i < MXCLUSTERS; i++) begin
            fa[i*MXADRBITS +: MXADRBITS] = 11'(5 * (i + 1));
            fc[i*MXCNTBITS +: MXCNTBITS] = 3'(i);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake and watches stability under stall.
    logic                stalled = 1'b0;
    logic [WORDBITS-1:0] held_data;
    logic                held_last;
    exp_t                got;

    always @(negedge clock4x) begin
        if (reset) begin
            stalled <= 1'b0;
        end else if (tx_if.tx_valid) begin
            if (stalled) begin
                check("stall tx_data stable", tx_if.tx_data, held_data);
                check("stall tx_last stable", tx_if.tx_last, held_last);
            end
            if (tx_if.tx_ready) begin
                check("word expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    got = exp_q.pop_front();
                    check("tx_data", tx_if.tx_data, got.data);
                    check("tx_last", tx_if.tx_last, got.last);
`ifdef CLUSTER_SER_HEADER_EN
                    check("tx_sof", tx_if.tx_sof, got.sof);
`endif
                end
                stalled <= 1'b0;
            end else begin
                stalled   <= 1'b1;
                held_data <= tx_if.tx_data;
                held_last <= tx_if.tx_last;
            end
        end else begin
            stalled <= 1'b0;
        end
    end

    initial begin
        int   n;
        logic rdy_pat [4];
        tx_if.tx_ready = 1'b0;

        repeat (3) step(1'b0, '0, '0, 1'b1, 1'b1);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // Full ramp frame with downstream always ready
        make_ramp();
        step(1'b1, fa, fc, 1'b1, 1'b0);
        drain();

        // Two valid clusters then empties
        fa = {MXCLUSTERS{11'h7FF}};
        fc = '1;
        fa[0 +: MXADRBITS]         = 11'd3;
        fa[MXADRBITS +: MXADRBITS] = 11'd7;
        fc[0 +: MXCNTBITS]         = 3'd2;
        fc[MXCNTBITS +: MXCNTBITS] = 3'd5;
        step(1'b1, fa, fc, 1'b1, 1'b0);
        drain();

        // Empty frame
        fa = {MXCLUSTERS{11'h7FF}};
        fc = '1;
        step(1'b1, fa, fc, 1'b1, 1'b0);
        drain();

        // Ready toggling 1,0,0,1 with a dropped load three cycles after the accepted one
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        make_ramp();
        step(1'b1, fa, fc, 1'b1, 1'b0);
        for (int j = 1; j < 40; j++) step(j == 3, fa, fc, rdy_pat[j % 4], 1'b0);
        drain();

        // Saturate the drop counter behind a stalled frame
        step(1'b1, fa, fc, 1'b0, 1'b0);
        for (int j = 0; j < 260; j++) step(1'b1, fa, fc, 1'b0, 1'b0);
        drain();
        check("overflow saturated", overflow_cnt, 8'd255);

        // Reset while the 4th word is presented, then a clean frame
        make_ramp();
        step(1'b1, fa, fc, 1'b1, 1'b0);
        for (int j = 1; j < 4; j++) step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b1);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b1, fa, fc, 1'b1, 1'b0);
        drain();

        // Random frames, random backpressure, random loads while busy
        for (int t = 0; t < 3000; t++) begin
            n = $urandom_range(0, MXCLUSTERS);
            for (int i = 0; i < MXCLUSTERS; i++) begin
                if (i < n)       fa[i*MXADRBITS +: MXADRBITS] = 11'($urandom_range(0, 2046));
                else if (i == n) fa[i*MXADRBITS +: MXADRBITS] = 11'h7FF;
                else             fa[i*MXADRBITS +: MXADRBITS] = ($urandom % 2) ? 11'h7FF : 11'($urandom_range(0, 2046));
                fc[i*MXCNTBITS +: MXCNTBITS] = 3'($urandom);
            end
            step(($urandom % 6) == 0, fa, fc, ($urandom % 4) != 0, 1'b0);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
